shiftreg_frame_sync: RTL and testbench

//  Downstream consumer of the 8-bit delay-line shift register. Hunts the delayed byte stream
//  for a sync byte, captures a fixed-length payload frame, and verifies a trailing 8-bit checksum.

---
 rtl/shiftreg_frame_sync.sv | 160 ++++++++++++++++
 tb/tb_shiftreg_frame_sync.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_frame_sync.sv
// shiftreg_frame_sync
//   Consumes the byte stream coming out of an 8-bit delay-line shift register.
//   It hunts for a sync byte, captures a fixed-length payload frame, and checks
//   the trailing 8-bit checksum. Payload bytes are buffered in a small FIFO and
//   presented on a valid/ready output. The result of each frame is reported
//   as a one-cycle frame_ok or frame_err pulse.
//
// Handshake: a byte moves from the output on every rising edge where
//   out_valid && out_ready. out_valid depends only on FIFO occupancy, never on
//   out_ready. While out_valid && !out_ready, out_data and out_last hold.
//   When out_valid is 0, out_data and out_last read as 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_en      in   in_data carries a new byte when 1
//   in_data    in   [7:0] byte from the delay line
//   out_data   out  [7:0] FIFO head payload byte
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer accepts the head
//   out_last   out  head byte is the last payload byte of its frame
//   frame_ok   out  1-cycle pulse: checksum good and no byte dropped
//   frame_err  out  1-cycle pulse: checksum bad or a byte dropped
//   overflow   out  sticky: a payload byte was dropped since reset
//   state      out  [1:0] FSM state, 0=HUNT 1=PAYLOAD 2=CHECK
module shiftreg_frame_sync #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         FRAME_LEN  = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_en,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       overflow,
  output logic [1:0] state
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam int         PW       = AW + 1;
  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] sum_q, sum_d;
  logic       drop_q, drop_d;
  logic       ok_d, err_d;
  logic       frame_ok_q, frame_err_q;
  logic       overflow_q;

  // FIFO storage: {last, byte}
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [8:0]    head;
  logic          empty, full;
  logic          pop, push_req, push, drop_now;
  logic          is_last;
  logic [7:0]    chk_sum;

  // The extra pointer MSB tells a full FIFO from an empty one when the
  // index bits coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop      = !empty && out_ready;
  assign push_req = in_en && (state_q == PAYLOAD);
  // A pop in the same cycle frees the slot the push needs.
  assign push     = push_req && (!full || pop);
  assign drop_now = push_req && !push;
  assign is_last  = (count_q == LAST_IDX);
  assign chk_sum  = sum_q + in_data;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    drop_d  = drop_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    if (in_en) begin
      case (state_q)
        HUNT: begin
          if (in_data == SYNC_BYTE) begin
            state_d = PAYLOAD;
            count_d = 8'd0;
            sum_d   = 8'd0;
            drop_d  = 1'b0;
          end
        end
        PAYLOAD: begin
          // A sync-valued byte here is ordinary data. A dropped byte still
          // counts toward the length and the checksum.
          sum_d   = chk_sum;
          count_d = count_q + 8'd1;
          if (drop_now) drop_d = 1'b1;
          if (is_last) state_d = CHECK;
        end
        CHECK: begin
          // The checksum byte is never checked for sync.
          if ((chk_sum == 8'd0) && !drop_q) ok_d = 1'b1;
          else err_d = 1'b1;
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      count_q     <= 8'd0;
      sum_q       <= 8'd0;
      drop_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      drop_q      <= drop_d;
      frame_ok_q  <= ok_d;
      frame_err_q <= err_d;
      overflow_q  <= overflow_q | drop_now;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {is_last, in_data};
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_data  = out_valid ? head[7:0] : 8'h00;
  assign out_last  = out_valid ? head[8]   : 1'b0;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign state     = state_q;

endmodule

// File: tb/tb_shiftreg_frame_sync.sv
module tb_shiftreg_frame_sync;

  logic       clk;
  logic       rst_n;
  logic       in_en;
  logic [7:0] in_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic       overflow;
  logic [1:0] state;

  int total;
  int bad;
  int ok_cnt;
  int err_cnt;
  logic toggle_ready;
  logic [8:0] exp_q[$];

  shiftreg_frame_sync dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .overflow(overflow), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // Scoreboard: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got last=%0b data=%02h, expected nothing", out_last, out_data);
        end else begin
          logic [8:0] exp;
          exp = exp_q.pop_front();
          if ({out_last, out_data} !== exp) begin
            bad++;
            $display("FAIL out_byte: got last=%0b data=%02h, expected last=%0b data=%02h",
                     out_last, out_data, exp[8], exp[7:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (toggle_ready) out_ready = ~out_ready;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    in_en   = 1'b1;
    in_data = b;
    step();
    in_en   = 1'b0;
    in_data = 8'($urandom_range(0, 255));
    repeat (gap) step();
  endtask

  // Sends sync, payload 01..10 and chk; only the first 'keep' payload bytes
  // are expected to reach the output.
  task automatic send_frame(input logic [7:0] chk, input int gap, input int keep);
    drive_byte(8'hA5, gap);
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] b;
      b = 8'(i);
      if (i <= keep) exp_q.push_back({(i == 16), b});
      drive_byte(b, gap);
    end
    drive_byte(chk, gap);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain: %0d expected bytes left, out_valid=%0b", exp_q.size(), out_valid);
    end
  endtask

  task automatic check_pulses(input string name, input int ok_exp, input int err_exp);
    total++;
    if (ok_cnt !== ok_exp || err_cnt !== err_exp) begin
      bad++;
      $display("FAIL %s_pulses: ok=%0d err=%0d, expected ok=%0d err=%0d",
               name, ok_cnt, err_cnt, ok_exp, err_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_en = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    total++;
    if ({out_valid, out_data, out_last, frame_ok, frame_err, overflow, state} !== 15'd0) begin
      bad++;
      $display("FAIL reset: valid=%0b data=%02h last=%0b ok=%0b err=%0b ovf=%0b state=%0d, expected all 0",
               out_valid, out_data, out_last, frame_ok, frame_err, overflow, state);
    end
  endtask

  task automatic test_good_frame();
    ok_cnt = 0; err_cnt = 0;
    out_ready = 1'b1;
    send_frame(8'h78, 0, 16);
    drain();
    repeat (3) step();
    check_pulses("good", 1, 0);
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL good_state: got %0d, expected 0", state);
    end
  endtask

  task automatic test_bad_checksum();
    ok_cnt = 0; err_cnt = 0;
    out_ready = 1'b1;
    send_frame(8'h00, 0, 16);
    drain();
    repeat (3) step();
    check_pulses("badchk", 0, 1);
  endtask

  task automatic test_gaps();
    ok_cnt = 0; err_cnt = 0;
    out_ready = 1'b1;
    drive_byte(8'h00, 0);
    drive_byte(8'hFF, 0);
    drive_byte(8'h5A, 0);
    send_frame(8'h78, 3, 16);
    drain();
    repeat (3) step();
    check_pulses("gaps", 1, 0);
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL gaps_state: got %0d, expected 0", state);
    end
  endtask

  task automatic test_overflow();
    ok_cnt = 0; err_cnt = 0;
    out_ready = 1'b0;
    send_frame(8'h78, 0, 4);
    repeat (3) step();
    check_pulses("ovf", 0, 1);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag: got %0b, expected 1", overflow);
    end
    total++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h01}) begin
      bad++;
      $display("FAIL ovf_hold: valid=%0b last=%0b data=%02h, expected valid=1 last=0 data=01",
               out_valid, out_last, out_data);
    end
    out_ready = 1'b1;
    drain();
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got %0b, expected 1", overflow);
    end
  endtask

  task automatic test_mid_reset();
    ok_cnt = 0; err_cnt = 0;
    out_ready = 1'b1;
    drive_byte(8'hA5, 0);
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] b;
      b = 8'(i);
      exp_q.push_back({1'b0, b});
      drive_byte(b, 0);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    total++;
    if ({out_valid, state, overflow} !== 4'd0) begin
      bad++;
      $display("FAIL midrst_state: valid=%0b state=%0d ovf=%0b, expected all 0",
               out_valid, state, overflow);
    end
    repeat (3) step();
    check_pulses("midrst", 0, 0);
    send_frame(8'h78, 0, 16);
    drain();
    repeat (3) step();
    check_pulses("midrst_after", 1, 0);
  endtask

  task automatic test_back_to_back();
    ok_cnt = 0; err_cnt = 0;
    out_ready = 1'b1;
    toggle_ready = 1'b1;
    send_frame(8'h78, 1, 16);
    send_frame(8'h78, 1, 16);
    toggle_ready = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) step();
    check_pulses("b2b", 2, 0);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_overflow: got %0b, expected 0", overflow);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    ok_cnt = 0;
    err_cnt = 0;
    toggle_ready = 1'b0;
    rst_n = 1'b0;
    in_en = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_gaps();
    test_overflow();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
